// File: rtl/instruction_invalidation_queue_pkg.sv
// Shared types for the instruction invalidation queue.
package instruction_invalidation_queue_pkg;

   localparam int INV_ADDR_W = 30;

   // Word address of an invalidation request.
   typedef logic [31:2] inv_addr_t;

   // Width of an occupancy counter able to hold 0..depth.
   function automatic int inv_count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/instruction_invalidation_queue_fifo.sv
// Storage FIFO for the invalidation queue: DEPTH entries (power of two),
// registered occupancy count, no fall-through. Push and pop may coincide.
module instruction_invalidation_queue_fifo
   import instruction_invalidation_queue_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = INV_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic [inv_count_w(DEPTH)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = inv_count_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;

   // Next pointers and count; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless while empty so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/instruction_invalidation_queue.sv
// Invalidation request queue: buffers word-address invalidations from the
// distributor and issues them one at a time to the I-cache/fetch engine,
// waiting for each completion before issuing the next.
// Optional feature macro: INV_QUEUE_COALESCE_EN -- drop a request that
// matches the most recently pushed entry while that entry is still queued.
module instruction_invalidation_queue
   import instruction_invalidation_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  inv_addr_t in_inv_addr,
   input  logic      in_inv_valid,
   output logic      in_inv_ready,
   output logic      in_inv_outstanding,
   output inv_addr_t out_inv_addr,
   output logic      out_inv_valid,
   input  logic      out_inv_completed
);

   localparam int CW = inv_count_w(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} inv_queue_state_t;

   inv_queue_state_t state_q, state_d;
   inv_addr_t        out_addr_q, out_addr_d;

   logic [CW-1:0] fifo_count;
   inv_addr_t     fifo_rd_data;
   logic          fifo_full, fifo_empty;
   logic          accept, coalesce, enq, pop;

   assign fifo_full  = (fifo_count == CW'(DEPTH));
   assign fifo_empty = (fifo_count == '0);

   // Ready comes from the registered count only, so a same-cycle pop never opens it.
   assign in_inv_ready = !rst && !fifo_full;
   assign accept       = in_inv_valid && in_inv_ready;
   assign enq          = accept && !coalesce;

`ifdef INV_QUEUE_COALESCE_EN
   inv_addr_t last_q, last_d;

   // Merge only against a still-queued newest entry; if that lone entry leaves
   // this cycle it is going in flight, so the new request must be kept.
   always_comb begin
      coalesce = accept && !fifo_empty && (in_inv_addr == last_q)
                 && !((fifo_count == CW'(1)) && pop);
      last_d   = last_q;
      if (enq) last_d = in_inv_addr;
   end

   // Address of the most recently enqueued entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= '0;
      else     last_q <= last_d;
   end
`else
   assign coalesce = 1'b0;
`endif

   instruction_invalidation_queue_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (INV_ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (enq),
      .pop     (pop),
      .wr_data (in_inv_addr),
      .rd_data (fifo_rd_data),
      .count   (fifo_count)
   );

   // Issue FSM: pop the head into the address register whenever we move to ISSUE.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      out_addr_d = out_addr_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (out_inv_completed) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) out_addr_d = fifo_rd_data;
   end

   // FSM state and issued-address registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         out_addr_q <= out_addr_d;
      end
   end

   assign out_inv_valid      = (state_q == ISSUE);
   assign out_inv_addr       = out_addr_q;
   assign in_inv_outstanding = !fifo_empty || (state_q != IDLE);

   // A completion with nothing in flight is ignored by the FSM; flag it in simulation.
   always @(posedge clk) begin
      if (!rst && state_q == IDLE)
         assert (!out_inv_completed)
            else $warning("out_inv_completed seen while idle; ignored");
   end

endmodule
